// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Optional combinational bypass is enabled with FETCH_BYPASS_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DROP
  } fetch_state_t;

  localparam int PC_STEP = 4;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundles for the fetch unit: instruction memory and decode side.
// Both use master (fetch side) and slave (peer side) modports.
interface imem_if #(
  parameter int XLEN = 64
);
  import fetch_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [ILEN-1:0] rdata;

  modport master (
    output req, addr,
    input  ack, rdata
  );

  modport slave (
    input  req, addr,
    output ack, rdata
  );
endinterface

interface dec_if #(
  parameter int XLEN = 64
);
  import fetch_pkg::*;

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [ILEN-1:0] instr;

  modport master (
    output valid, pc, pc_plus4, instr,
    input  ready
  );

  modport slave (
    input  valid, pc, pc_plus4, instr,
    output ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} pairs with push, pop and flush.
// Storage resets to zero so the head reads as zero out of reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [XLEN-1:0]        wr_pc,
  input  logic [ILEN-1:0]        wr_instr,
  output logic [XLEN-1:0]        rd_pc,
  output logic [ILEN-1:0]        rd_instr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [ILEN-1:0] in_mem [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i] <= '0;
        in_mem[i] <= '0;
      end
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc_mem[wp] <= wr_pc;
        in_mem[wp] <= wr_instr;
        wp         <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rd_pc    = pc_mem[rp];
  assign rd_instr = in_mem[rp];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC owner, imem req/ack, prefetch FIFO.
// Define FETCH_BYPASS_EN for zero-latency delivery into an empty FIFO.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clock,
  input  logic            reset,
  imem_if.master          imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  dec_if.master           dec
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  logic            req_q;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_instr;
  logic [XLEN-1:0] dec_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   cnt_nxt;
  logic            full;
  logic            empty;
  logic            run_ack;
  logic            drop_ack;
  logic            byp;
  logic            push;
  logic            pop;
  logic            credit;
  logic            hold_redir;
  logic            go_redir;
  logic            drop_done;
  logic            fetched;
  logic            wake;

  assign redir_tgt = redirect_pc & ~XLEN'(3);
  assign run_ack   = (state == RUN) & imem.ack;
  assign drop_ack  = (state == DROP) & imem.ack;

`ifdef FETCH_BYPASS_EN
  assign byp = run_ack & ~redirect_valid
             & empty & dec.ready;
`else
  assign byp = 1'b0;
`endif

  assign push = run_ack & ~redirect_valid
              & ~byp & ~full;
  assign pop  = dec.ready & ~empty
              & ~redirect_valid;

  // Occupancy after this edge; a new request is issued against it.
  assign cnt_nxt = redirect_valid ? '0
                 : count + CW'(push) - CW'(pop);
  assign credit  = cnt_nxt < CW'(DEPTH);

  assign hold_redir = redirect_valid
                    & (state != IDLE) & ~imem.ack;
  assign go_redir   = redirect_valid & ~hold_redir;
  assign drop_done  = ~redirect_valid & drop_ack;
  assign fetched    = ~redirect_valid & run_ack;
  assign wake       = ~redirect_valid
                    & (state == IDLE) & credit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      fetch_pc <= RESET_VECTOR;
      target   <= RESET_VECTOR;
    end else begin
      unique case (1'b1)
        hold_redir: begin
          state  <= DROP;
          req_q  <= 1'b1;
          target <= redir_tgt;
        end
        go_redir: begin
          state    <= RUN;
          req_q    <= 1'b1;
          fetch_pc <= redir_tgt;
        end
        drop_done: begin
          state    <= RUN;
          req_q    <= 1'b1;
          fetch_pc <= target;
        end
        fetched: begin
          state    <= credit ? RUN : IDLE;
          req_q    <= credit;
          fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        end
        wake: begin
          state <= RUN;
          req_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  fetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_pc    (fetch_pc),
    .wr_instr (imem.rdata),
    .rd_pc    (head_pc),
    .rd_instr (head_instr),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign imem.req  = req_q;
  assign imem.addr = fetch_pc;

  assign dec_pc       = byp ? fetch_pc : head_pc;
  assign dec.pc       = dec_pc;
  assign dec.pc_plus4 = dec_pc + XLEN'(PC_STEP);
  assign dec.instr    = byp ? imem.rdata : head_instr;
  assign dec.valid    = ~empty | byp;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the RV64 core; successor to the fixed single-cycle PC register and the +4/branch PC muxes. It owns the fetch PC, runs a req/ack protocol to instruction memory with one transfer outstanding, and buffers fetched {pc, instr} pairs in a DEPTH-entry prefetch FIFO. Decode consumes the FIFO over a valid/ready handshake. A redirect from the execute stage (branch or jump) flushes the FIFO and discards any in-flight stale response.

## Interface
- XLEN, 64, PC and address width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_VECTOR, 64'h0, first fetch address after reset
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address; word-aligned, held stable while imem_req=1 and imem_ack=0
- imem_ack  in  1  transfer complete this cycle; imem_rdata valid
- imem_rdata  in  32  fetched instruction
- redirect_valid  in  1  redirect fetch this cycle
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (treated as 0)
- dec_valid  out  1  FIFO head valid
- dec_ready  in  1  decode accepts head
- dec_pc  out  XLEN  PC of head instruction
- dec_pc_plus4  out  XLEN  dec_pc+4, wraps mod 2^XLEN
- dec_instr  out  32  head instruction

## Operation
- States: IDLE (no request), RUN (imem_req=1 at fetch_pc), DROP (imem_req=1 at stale address; response to be discarded).
- Credit: new request issued only if count + outstanding < DEPTH; otherwise IDLE.
- RUN, ack, no redirect: push {fetch_pc, imem_rdata}; fetch_pc += 4; stay RUN if credit remains, else IDLE.
- IDLE → RUN as soon as credit is available (the cycle after a pop frees a slot).
- Redirect, no request outstanding or ack this cycle: flush FIFO; fetch_pc <= redirect_pc & ~3; → RUN.
- Redirect, request outstanding without ack: flush FIFO; target latched; imem_addr held unchanged → DROP.
- DROP, ack: discard data; → RUN at latched target. A further redirect in DROP overwrites the target and stays in DROP.
- Same cycle, redirect + dec pop: flush wins. Pop is not double-counted.
- Same cycle, push + pop at full/empty edge: count is unchanged. FIFO pointers wrap mod DEPTH.
- Decode sees nothing fetched before a redirect once that redirect has been sampled.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_VECTOR, dec_valid=0, dec_pc=0, dec_pc_plus4=4, dec_instr=0, state IDLE, count=0.
- First rising edge after reset deasserts: → RUN, imem_req=1, imem_addr=RESET_VECTOR.
- Zero-wait memory (ack in request cycle): sustained one instruction per cycle while decode is ready.
- Fetch-to-decode latency: dec_valid rises the cycle after ack.
- Redirect to first new request: 1 cycle, or 1 cycle after the stale ack when in DROP.
- Reset asserted mid-transfer: all outputs take reset values immediately (asynchronous). Memory must tolerate an abandoned request.

## Configuration
- FETCH_BYPASS_EN defined:
  - When the FIFO is empty and decode is ready, an acked instruction is presented combinationally on dec_* in the ack cycle and not written to the FIFO.
  - Fetch-to-decode latency becomes 0.
  - Bypass is suppressed in DROP and on redirect cycles.
- Undefined: all instructions pass through the FIFO; latency 1.

## Structure
- Shared package fetch_pkg:
  - fetch_state_t enum (IDLE, RUN, DROP)
  - PC_STEP=4
  - ILEN=32
  - NOP_INSTR=32'h00000013
- Sub-module fetch_fifo: DEPTH × (XLEN+32) storage with push/pop/flush, count, full/empty outputs.

## Test plan
- Reset release, zero-wait memory returning addr-derived data, dec_ready=1 → addresses 0,4,8,… back-to-back; dec_instr matches per pc; dec_valid first high at cycle 2 (cycle 1 with FETCH_BYPASS_EN).
- dec_ready=0, DEPTH=4 → exactly 4 acks accepted, then imem_req=0; one pop → imem_req=1 the next cycle.
- Memory with 3-cycle ack latency; redirect_pc=0x100 in wait cycle 1 → imem_addr held, stale ack discarded, next request at 0x100, no stale entry reaches decode.
- Redirect to 0x203 with FIFO holding 3 entries → FIFO empty next cycle; fetch restarts at 0x200.
- Redirect and ack and pop all in one cycle → data dropped, count=0, next imem_addr=redirect target.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC → following fetch at 0x0; dec_pc_plus4=0.
